// File: rtl/duty_ramp_ctrl_if.sv
// rtl/duty_ramp_ctrl_if.sv - target-duty command handshake between a controller and the ramp generator
interface duty_ramp_ctrl_if #(
  parameter int DW = 10
);
  logic          cmd_valid;
  logic [DW-1:0] cmd_target;
  logic          cmd_ready;

  modport master (output cmd_valid, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/duty_ramp_ctrl.sv
// rtl/duty_ramp_ctrl.sv - soft-start/soft-stop duty slew generator feeding the PWM duty input
// Slews duty toward the accepted target by STEP once per PWM period; estop forces duty to 0.
module duty_ramp_ctrl #(
  parameter int DW       = 10,
  parameter int STEP     = 8,
  parameter int TICK_DIV = 1024,
  parameter int MAX_DUTY = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_estop,
  duty_ramp_ctrl_if.slave      cmd,
  output logic [DW-1:0]        o_duty,
  output logic                 o_at_target,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_STOP = 3'd4
  } state_t;

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW:0]   STEP_X = (DW+1)'(STEP);
  localparam logic [DW:0]   MAX_X  = (DW+1)'(MAX_DUTY);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] r_tgt;
  logic [DW-1:0] w_duty_nxt;
  logic [DW-1:0] w_eff;
  logic [DW:0]   w_duty_x;
  logic [DW:0]   w_eff_x;
  logic [DW:0]   w_up_gap;
  logic [DW:0]   w_dn_gap;
  logic [DW:0]   w_up_sum;
  logic [DW:0]   w_dn_dif;
  logic [DW:0]   w_target_x;
  logic          w_hs;

  assign w_tick = (r_cnt == TICK_LAST);

  // Free-running in every state so ticks stay aligned to the PWM period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cmd.cmd_ready = !rst && (r_state != ST_STOP);
  assign w_hs          = cmd.cmd_valid && cmd.cmd_ready;
  assign w_eff         = i_enable ? r_tgt : '0;
  assign w_duty_x      = {1'b0, r_duty};
  assign w_eff_x       = {1'b0, w_eff};
  assign w_up_gap      = w_eff_x - w_duty_x;
  assign w_dn_gap      = w_duty_x - w_eff_x;
  assign w_up_sum      = w_duty_x + STEP_X;
  assign w_dn_dif      = w_duty_x - STEP_X;
  assign w_target_x    = {1'b0, cmd.cmd_target};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt <= '0;
    end else if (i_estop) begin
      r_tgt <= '0;
    end else if (w_hs) begin
      r_tgt <= (w_target_x > MAX_X) ? MAX_X[DW-1:0] : cmd.cmd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
    end
  end

  // A retarget that flips direction costs one clock with duty frozen.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    if (i_estop) begin
      w_state_nxt = ST_STOP;
      w_duty_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_eff > r_duty)      w_state_nxt = ST_UP;
          else if (w_eff < r_duty) w_state_nxt = ST_DOWN;
        end
        ST_UP: begin
          if (w_eff == r_duty)     w_state_nxt = (w_eff == '0) ? ST_IDLE : ST_HOLD;
          else if (w_eff < r_duty) w_state_nxt = ST_DOWN;
          else if (w_tick)         w_duty_nxt  = (w_up_gap <= STEP_X) ? w_eff : w_up_sum[DW-1:0];
        end
        ST_DOWN: begin
          if (w_eff == r_duty)     w_state_nxt = (w_eff == '0) ? ST_IDLE : ST_HOLD;
          else if (w_eff > r_duty) w_state_nxt = ST_UP;
          else if (w_tick)         w_duty_nxt  = (w_dn_gap <= STEP_X) ? w_eff : w_dn_dif[DW-1:0];
        end
        ST_STOP: begin
          if (!i_enable) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  assign o_duty      = r_duty;
  assign o_state     = r_state;
  assign o_at_target = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign o_busy      = (r_state == ST_UP) || (r_state == ST_DOWN);

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// tb/tb_duty_ramp_ctrl.sv - scoreboard bench for duty_ramp_ctrl against a behavioural slew model
module tb_duty_ramp_ctrl;
  localparam int DW       = 10;
  localparam int STEP     = 8;
  localparam int TICK_DIV = 4;
  localparam int MAX_DUTY = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          estop = 1'b0;
  logic [DW-1:0] duty;
  logic          at_target;
  logic          busy;
  logic [2:0]    state;

  duty_ramp_ctrl_if #(.DW(DW)) cmd_if ();

  duty_ramp_ctrl #(
    .DW(DW), .STEP(STEP), .TICK_DIV(TICK_DIV), .MAX_DUTY(MAX_DUTY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (enable),
    .i_estop    (estop),
    .cmd        (cmd_if),
    .o_duty     (duty),
    .o_at_target(at_target),
    .o_busy     (busy),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] duty;
    logic [2:0]    state;
    logic          at_target;
    logic          busy;
    logic          ready;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: 0 idle, 1 hold, 2 ramping up, 3 ramping down, 4 stopped.
  int m_duty, m_tgt, m_cnt, m_st;

  function automatic void model_reset();
    m_duty = 0; m_tgt = 0; m_cnt = 0; m_st = 0;
  endfunction

  function automatic void model_step(input bit r, input bit en, input bit es, input bit v, input int tg);
    int eff;
    bit tick;
    bit rdy;
    if (r) begin
      model_reset();
      return;
    end
    tick  = (m_cnt == TICK_DIV - 1);
    m_cnt = (m_cnt + 1) % TICK_DIV;
    rdy   = (m_st != 4);
    eff   = en ? m_tgt : 0;
    if (es) begin
      m_st = 4; m_duty = 0; m_tgt = 0;
      return;
    end
    if (v && rdy) m_tgt = (tg > MAX_DUTY) ? MAX_DUTY : tg;
    case (m_st)
      0, 1: begin
        if (eff > m_duty) m_st = 2;
        else if (eff < m_duty) m_st = 3;
      end
      2, 3: begin
        if (eff == m_duty) m_st = (eff == 0) ? 0 : 1;
        else if (eff > m_duty) begin
          if (m_st == 3) m_st = 2;
          else if (tick) m_duty = (m_duty + STEP > eff) ? eff : m_duty + STEP;
        end else begin
          if (m_st == 2) m_st = 3;
          else if (tick) m_duty = (m_duty - STEP < eff) ? eff : m_duty - STEP;
        end
      end
      4: if (!en) m_st = 0;
      default: ;
    endcase
  endfunction

  function automatic obs_t model_obs(input bit r);
    obs_t o;
    o.duty      = DW'(m_duty);
    o.state     = 3'(m_st);
    o.at_target = (m_st == 0) || (m_st == 1);
    o.busy      = (m_st == 2) || (m_st == 3);
    o.ready     = !r && (m_st != 4);
    return o;
  endfunction

  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.duty = duty; a.state = state; a.at_target = at_target; a.busy = busy; a.ready = cmd_if.cmd_ready;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got duty=%0d st=%0d at=%0b busy=%0b rdy=%0b, expected duty=%0d st=%0d at=%0b busy=%0b rdy=%0b",
                   $time, a.duty, a.state, a.at_target, a.busy, a.ready, e.duty, e.state, e.at_target, e.busy, e.ready);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    model_step(rst, enable, estop, cmd_if.cmd_valid, int'(cmd_if.cmd_target));
    exp_q.push_back(model_obs(rst));
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input int t);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = DW'(t);
    cycle();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic settle(input string name, input int bound);
    int n = 0;
    cycle();
    while (!(state == 3'd0 || state == 3'd1 || state == 3'd4) && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no settle within %0d cycles, state=%0d", name, bound, state);
    end
  endtask

  task automatic run_until_duty(input string name, input int d, input int bound);
    int n = 0;
    while (int'(duty) != d && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) begin
      n_checks++; n_fail++;
      $display("FAIL %s: duty never reached %0d, got %0d", name, d, duty);
    end
  endtask

  task automatic release_reset();
    #5 rst = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    model_reset();
    run(3);
    release_reset();
    check_eq("reset_duty", int'(duty), 0);
    check_eq("reset_at_target", int'(at_target), 1);

    enable = 1'b1;
    send(20);
    settle("up_20", 100);
    check_eq("hold_20_duty", int'(duty), 20);
    check_eq("hold_20_state", int'(state), 1);

    send(4);
    settle("down_4", 100);
    check_eq("hold_4_duty", int'(duty), 4);

    send(1023);
    settle("clamp", 2000);
    check_eq("clamp_duty", int'(duty), MAX_DUTY);

    send(0);
    settle("to_zero", 2000);
    check_eq("zero_state", int'(state), 0);

    send(200);
    run_until_duty("mid_40", 40, 100);
    send(24);
    settle("retarget_24", 100);
    check_eq("retarget_duty", int'(duty), 24);

    send(100);
    settle("up_100", 200);
    enable = 1'b0;
    settle("disable", 200);
    check_eq("disable_duty", int'(duty), 0);
    check_eq("disable_state", int'(state), 0);
    enable = 1'b1;
    settle("reenable", 200);
    check_eq("reenable_duty", int'(duty), 100);

    send(300);
    settle("up_300", 400);
    estop = 1'b1;
    cycle();
    check_eq("estop_duty", int'(duty), 0);
    check_eq("estop_state", int'(state), 4);
    check_eq("estop_ready", int'(cmd_if.cmd_ready), 0);
    estop = 1'b0;
    run(6);
    check_eq("stop_latched", int'(state), 4);
    enable = 1'b0;
    cycle();
    check_eq("stop_exit", int'(state), 0);

    enable = 1'b1;
    send(500);
    run(20);
    #6 rst = 1'b1;
    #1;
    check_eq("async_rst_duty", int'(duty), 0);
    check_eq("async_rst_state", int'(state), 0);
    model_reset();
    run(2);
    release_reset();
    send(64);
    settle("after_rst", 200);
    check_eq("after_rst_duty", int'(duty), 64);

    for (int i = 0; i < 600; i++) begin
      cmd_if.cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_if.cmd_target = DW'($urandom_range(0, 1023));
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      estop = ($urandom_range(0, 59) == 0);
      cycle();
    end
    cmd_if.cmd_valid = 1'b0;
    estop = 1'b0;
    run(5);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
